seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It consumes the 32-bit display word, 8-bit per-digit blink mask and 8-bit per-digit decimal-point mask produced by the display-channel multiplexer, and scans one digit at a time onto the anode and segment pins. The block latches a consistent snapshot of its inputs once per frame and applies digit blinking aligned to frame boundaries.

## Interface
- `SCAN_DIV`, 100000: clock cycles each digit stays active; legal range ≥ 2.
- `BLINK_FRAMES`, 32: frames per blink half-period; legal range ≥ 1.

- `clk` in 1: system clock.
- `rst` in 1: reset; synchronous and active-high.
- `disp_num` in 32: eight hex nibbles; digit i = `disp_num[4i+3:4i]`.
- `le_in` in 8: blink mask; bit i = 1 means digit i blinks.
- `point_in` in 8: decimal-point mask; bit i = 1 means the DP of digit i is lit.
- `an` out 8: anode enables, active-low; bit i drives digit i.
- `seg` out 8: segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
- `frame_start` out 1: one-cycle pulse; asserted in the cycle after a new snapshot is captured.

## Operation
- Prescaler `pre` counts 0..SCAN_DIV-1. `tick` = (`pre` == SCAN_DIV-1).
- Digit index `idx` (3 bits) advances on `tick` and wraps 7→0.
- Snapshot: on a `tick` that takes `idx` from 7 to 0, `disp_num`, `le_in` and `point_in` are captured into shadow registers. `frame_start` is registered from the same condition. Inputs are ignored at all other times.
- Blink: `bcnt` counts `frame_start` events 0..BLINK_FRAMES-1. On the event that wraps it, `blink_ph` toggles. Blink phase therefore changes only on frame boundaries.
- Output encoding (registered from `idx` and the shadows):
  - `an` = all-ones with bit `idx` cleared.
  - `seg[6:0]` = hex_to_seg7(shadow nibble `idx`).
  - `seg[7]` = ~shadow_point[`idx`].
  - If shadow_le[`idx`] and `blink_ph` are both 1, `seg` = 8'hFF. The anode stays enabled, so scan timing is unchanged.
- Hex codes for `seg[6:0]`, with DP off:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E

## Timing
- Reset values:
  - `pre` = SCAN_DIV-1, `idx` = 7, shadows = 0, `bcnt` = 0, `blink_ph` = 0.
  - `an` = 8'hFF, `seg` = 8'hFF, `frame_start` = 0.
- The first clock edge with `rst` low is a `tick` with `idx` 7→0. This edge captures the snapshot and sets `frame_start` = 1.
- `an`/`seg` follow `idx`/shadow changes one clock later. Each digit is shown for exactly SCAN_DIV cycles. A frame is 8·SCAN_DIV cycles.
- `frame_start` is high for exactly one cycle per frame. It is high during the first cycle in which `idx` = 0. It is the cycle before `an` = 8'hFE.
- Input changes mid-frame take effect only at the next snapshot.
- A full blink period is 2·BLINK_FRAMES frames. On the first frame after reset the digit is visible (`blink_ph` = 0).
- `rst` asserted mid-frame: the next edge restores all reset values and outputs blank immediately. There is no partial-frame completion.
- `rst` takes precedence over `tick`.

## Structure
- Shared package `seg7_pkg` holds:
  - `SEG_BLANK` = 8'hFF and `AN_NONE` = 8'hFF.
  - The 16-entry hex segment constant array.
- Sub-module `hex_to_seg7` is a combinational nibble→7-bit decoder. It is instantiated once, on the shadow nibble selected by `idx`.
- Prescaler width is $clog2(SCAN_DIV). Blink counter width is $clog2(BLINK_FRAMES)+1.

## Test plan
All scenarios use SCAN_DIV=4, BLINK_FRAMES=2.
- Reset, then release with `disp_num`=0x00000000:
  - During reset: `an`=FF, `seg`=FF, `frame_start`=0.
  - First edge after release: `frame_start`=1.
  - Next edge: `an`=FE, `seg`=C0.
- `disp_num`=0x76543210, `le_in`=0, `point_in`=0:
  - `an` steps FE,FD,FB,F7,EF,DF,BF,7F, 4 cycles each.
  - `seg` steps C0,F9,A4,B0,99,92,82,F8.
  - `frame_start` is seen every 32 cycles.
- `disp_num`=0x00000008, `point_in`=0x01: digit 0 `seg`=00, digits 1–7 `seg`=C0.
- Snapshot isolation: change `disp_num` 0x11111111→0x22222222 while digit 3 is active. Digits 4–7 still show F9, and A4 appears only after the next `frame_start`.
- Blink with `le_in`=0x80, `disp_num`=0xF0000000:
  - Digit 7 shows 8E in frames 0–1 and FF in frames 2–3, repeating every 4 frames.
  - `an`=7F in every frame; other digits are unaffected.
- Reset pulse while digit 5 is active: the next edge gives `an`=FF, `seg`=FF. After release the sequence restarts exactly as in the first scenario.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: blank patterns and
// the active-low hex glyph table.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_NONE   = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} glyphs; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup of the glyph for this nibble.
  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with per-frame
// input snapshot and frame-aligned digit blinking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_num,
  input  logic [7:0]  le_in,
  input  logic [7:0]  point_in,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_start
);

  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int BCNT_W = $clog2(BLINK_FRAMES) + 1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [2:0]        idx_q, idx_d;
  logic [31:0]       shadow_num_q, shadow_num_d;
  logic [7:0]        shadow_le_q, shadow_le_d;
  logic [7:0]        shadow_point_q, shadow_point_d;
  logic              shadow_ph_q, shadow_ph_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic              frame_start_q, frame_start_d;
  logic [7:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic              tick;
  logic              snap;
  logic [3:0]        cur_nibble;
  logic [6:0]        cur_glyph;

  assign tick = (pre_q == PRE_W'(SCAN_DIV - 1));
  assign snap = tick && (idx_q == 3'd7);

  assign cur_nibble = shadow_num_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nibble),
    .seg    (cur_glyph)
  );

  // Prescaler and digit index: each digit holds for SCAN_DIV cycles.
  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    idx_d = tick ? idx_q + 3'd1 : idx_q;
  end

  // Snapshot of inputs at the frame boundary. The blink phase is latched
  // here too so a phase change from the counter below never lands mid-frame.
  always_comb begin
    shadow_num_d   = shadow_num_q;
    shadow_le_d    = shadow_le_q;
    shadow_point_d = shadow_point_q;
    shadow_ph_d    = shadow_ph_q;
    frame_start_d  = snap;
    if (snap) begin
      shadow_num_d   = disp_num;
      shadow_le_d    = le_in;
      shadow_point_d = point_in;
      shadow_ph_d    = blink_ph_q;
    end
  end

  // Blink counter: counts frame_start pulses, toggles phase on wrap.
  always_comb begin
    bcnt_d     = bcnt_q;
    blink_ph_d = blink_ph_q;
    if (frame_start_q) begin
      if (bcnt_q == BCNT_W'(BLINK_FRAMES - 1)) begin
        bcnt_d     = '0;
        blink_ph_d = ~blink_ph_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Output encoding for the currently selected digit.
  always_comb begin
    an_d = ~(8'h01 << idx_q);
    if (shadow_le_q[idx_q] && shadow_ph_q) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = {~shadow_point_q[idx_q], cur_glyph};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q          <= PRE_W'(SCAN_DIV - 1);
      idx_q          <= 3'd7;
      shadow_num_q   <= '0;
      shadow_le_q    <= '0;
      shadow_point_q <= '0;
      shadow_ph_q    <= 1'b0;
      bcnt_q         <= '0;
      blink_ph_q     <= 1'b0;
      frame_start_q  <= 1'b0;
      an_q           <= AN_NONE;
      seg_q          <= SEG_BLANK;
    end else begin
      pre_q          <= pre_d;
      idx_q          <= idx_d;
      shadow_num_q   <= shadow_num_d;
      shadow_le_q    <= shadow_le_d;
      shadow_point_q <= shadow_point_d;
      shadow_ph_q    <= shadow_ph_d;
      bcnt_q         <= bcnt_d;
      blink_ph_q     <= blink_ph_d;
      frame_start_q  <= frame_start_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a cycle-count based
// reference model of scan position, frame snapshots and blink phase.
module tb_seg7_scan_driver;

   localparam int S     = 4;
   localparam int BF    = 2;
   localparam int FRAME = 8 * S;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dispNum;
   logic [7:0]  leIn;
   logic [7:0]  pointIn;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic        frameStart;

   int          edgeCount;
   int          checks;
   int          failures;
   logic [31:0] snapNum;
   logic [7:0]  snapLe;
   logic [7:0]  snapPt;

   seg7_scan_driver #(
      .SCAN_DIV     (S),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .disp_num    (dispNum),
      .le_in       (leIn),
      .point_in    (pointIn),
      .an          (an),
      .seg         (seg),
      .frame_start (frameStart)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Glyph table with the decimal point off, as listed for the display.
   function automatic logic [7:0] hexCode(input logic [3:0] nib);
      logic [7:0] code;
      case (nib)
         4'h0: code = 8'hC0;  4'h1: code = 8'hF9;
         4'h2: code = 8'hA4;  4'h3: code = 8'hB0;
         4'h4: code = 8'h99;  4'h5: code = 8'h92;
         4'h6: code = 8'h82;  4'h7: code = 8'hF8;
         4'h8: code = 8'h80;  4'h9: code = 8'h90;
         4'hA: code = 8'h88;  4'hB: code = 8'h83;
         4'hC: code = 8'hC6;  4'hD: code = 8'hA1;
         4'hE: code = 8'h86;  default: code = 8'h8E;
      endcase
      return code;
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h (edge %0d)",
                tag, observed, expected, edgeCount);
      end
   endtask

   // Advance one or more clocks; after each edge derive the expected outputs
   // from the number of edges since reset release and the frame snapshot.
   task automatic applyStimulus(input int cycles);
      logic [7:0] expAn;
      logic [7:0] expSeg;
      logic [7:0] code;
      logic       expFs;
      logic       phase;
      int         digit;
      int         nib;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         if (rst) begin
            edgeCount = 0;
            snapNum   = '0;
            snapLe    = '0;
            snapPt    = '0;
            expAn     = 8'hFF;
            expSeg    = 8'hFF;
            expFs     = 1'b0;
         end else begin
            edgeCount++;
            expFs = ((edgeCount - 1) % FRAME) == 0;
            if (edgeCount == 1) begin
               digit = 7;
               phase = 1'b0;
            end else begin
               digit = ((edgeCount - 2) % FRAME) / S;
               phase = ((((edgeCount - 2) / FRAME) / BF) % 2) == 1;
            end
            nib   = (snapNum >> (4 * digit)) & 32'hF;
            code  = hexCode(4'(nib));
            expAn = 8'hFF & ~(8'h01 << digit);
            if (snapLe[digit] && phase) begin
               expSeg = 8'hFF;
            end else begin
               expSeg = {~snapPt[digit], code[6:0]};
            end
            if (expFs) begin
               snapNum = dispNum;
               snapLe  = leIn;
               snapPt  = pointIn;
            end
         end
         checkOutput("an", an, expAn);
         checkOutput("seg", seg, expSeg);
         checkOutput("frame_start", {7'd0, frameStart}, {7'd0, expFs});
      end
   endtask

   function automatic int curDigit();
      return (edgeCount >= 2) ? ((edgeCount - 2) % FRAME) / S : -1;
   endfunction

   // Directed scenarios followed by a randomized run.
   initial begin
      checks    = 0;
      failures  = 0;
      edgeCount = 0;
      snapNum   = '0;
      snapLe    = '0;
      snapPt    = '0;
      rst       = 1'b1;
      dispNum   = 32'h0000_0000;
      leIn      = 8'h00;
      pointIn   = 8'h00;

      $display("[TB] reset and release with blank word");
      applyStimulus(3);
      rst = 1'b0;
      applyStimulus(2 * FRAME);

      $display("[TB] ascending digits");
      dispNum = 32'h7654_3210;
      applyStimulus(2 * FRAME);

      $display("[TB] eight with decimal point on digit 0");
      dispNum = 32'h0000_0008;
      pointIn = 8'h01;
      applyStimulus(2 * FRAME);

      $display("[TB] snapshot isolation");
      dispNum = 32'h1111_1111;
      pointIn = 8'h00;
      applyStimulus(FRAME);
      for (int k = 0; k < FRAME && curDigit() != 3; k++) applyStimulus(1);
      dispNum = 32'h2222_2222;
      applyStimulus(2 * FRAME);

      $display("[TB] blink on digit 7");
      rst     = 1'b1;
      applyStimulus(1);
      rst     = 1'b0;
      dispNum = 32'hF000_0000;
      leIn    = 8'h80;
      applyStimulus(8 * FRAME);

      $display("[TB] reset pulse while digit 5 active");
      for (int k = 0; k < FRAME && curDigit() != 5; k++) applyStimulus(1);
      rst = 1'b1;
      applyStimulus(1);
      rst     = 1'b0;
      dispNum = 32'h0000_0000;
      leIn    = 8'h00;
      pointIn = 8'h00;
      applyStimulus(FRAME + 2);

      $display("[TB] randomized inputs");
      for (int k = 0; k < 12 * FRAME; k++) begin
         if ($urandom_range(7) == 0) begin
            dispNum = $urandom;
            leIn    = 8'($urandom);
            pointIn = 8'($urandom);
         end
         rst = ($urandom_range(149) == 0);
         applyStimulus(1);
      end
      rst = 1'b0;
      applyStimulus(2 * FRAME);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
